// File: rtl/uart_receiver.sv
// 8N1 UART receive path: 2-flop line synchronizer, mid-bit oversampled decode,
// and a held-byte register with ready/read handshake plus framing and overrun flags.
module uart_receiver #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 clrn,
    input  logic                 rxd,
    input  logic                 rdn,
    output logic [DATA_BITS-1:0] d_out,
    output logic                 r_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [SW-1:0] HALF_CNT = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] LAST_CNT = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                 state_q, state_d;
    logic                   rxd_m_q, rxd_s_q;
    logic                   armed_q, armed_d;
    logic [SW-1:0]          scnt_q, scnt_d;
    logic [BW-1:0]          bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [DATA_BITS-1:0]   d_out_q, d_out_d;
    logic                   r_ready_q, r_ready_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   done;

    // Synchronizer resets low so the line must be seen high before arming.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rxd_m_q <= 1'b0;
            rxd_s_q <= 1'b0;
        end else begin
            rxd_m_q <= rxd;
            rxd_s_q <= rxd_m_q;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= IDLE;
            armed_q     <= 1'b0;
            scnt_q      <= '0;
            bcnt_q      <= '0;
            shreg_q     <= '0;
            d_out_q     <= '0;
            r_ready_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            scnt_q      <= scnt_d;
            bcnt_q      <= bcnt_d;
            shreg_q     <= shreg_d;
            d_out_q     <= d_out_d;
            r_ready_q   <= r_ready_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        scnt_d  = scnt_q;
        bcnt_d  = bcnt_q;
        shreg_d = shreg_q;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (rxd_s_q) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = START;
                    scnt_d  = '0;
                    armed_d = 1'b0;
                end
            end
            START: begin
                if (scnt_q == HALF_CNT) begin
                    if (!rxd_s_q) begin
                        state_d = DATA;
                        scnt_d  = '0;
                        bcnt_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    scnt_d = scnt_q + SW'(1);
                end
            end
            DATA: begin
                scnt_d = scnt_q + SW'(1);
                if (scnt_q == LAST_CNT) begin
                    shreg_d = shreg_q >> 1;
                    shreg_d[DATA_BITS-1] = rxd_s_q;
                    bcnt_d = bcnt_q + BW'(1);
                    if (bcnt_q == LAST_BIT) begin
                        state_d = STOP;
                        scnt_d  = '0;
                    end
                end
            end
            STOP: begin
                if (scnt_q == LAST_CNT) begin
                    done    = 1'b1;
                    state_d = IDLE;
                    scnt_d  = '0;
                end else begin
                    scnt_d = scnt_q + SW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A completing frame takes priority over a read in the same cycle.
    always_comb begin
        d_out_d     = d_out_q;
        r_ready_d   = r_ready_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        if (done) begin
            d_out_d     = shreg_q;
            frame_err_d = ~rxd_s_q;
            r_ready_d   = 1'b1;
            overrun_d   = r_ready_q & rdn;
        end else if (!rdn) begin
            r_ready_d   = 1'b0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end
    end

    assign d_out     = d_out_q;
    assign r_ready   = r_ready_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: drives 8N1 frames cycle by cycle and compares all
// outputs every cycle against a frame-level model of the receive/read rules.
module tb_uart_receiver;

    localparam int DB = 8;
    localparam int OS = 16;
    localparam int FRAME_LEN = 10 * OS;
    localparam int COMP_EDGE = 3 + OS / 2 + OS * DB + OS - 1 + 1;  // 155

    logic          clk = 1'b0;
    logic          clrn;
    logic          rxd;
    logic          rdn;
    logic [DB-1:0] d_out;
    logic          r_ready;
    logic          frame_err;
    logic          overrun;

    uart_receiver #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .rxd       (rxd),
        .rdn       (rdn),
        .d_out     (d_out),
        .r_ready   (r_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state: expected outputs plus one pending completion.
    int            edge_cnt = 0;
    int            comp_at = -1;
    logic [DB-1:0] pend_data;
    logic          pend_stop;
    logic [DB-1:0] e_data;
    logic          e_ready, e_ferr, e_ovr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_outs();
        return {21'b0, r_ready, frame_err, overrun, d_out};
    endfunction

    function automatic logic [31:0] exp_outs();
        return {21'b0, e_ready, e_ferr, e_ovr, e_data};
    endfunction

    function automatic logic frame_bit(input logic [DB-1:0] b, input logic stop, input int i);
        int k;
        k = i / OS;
        if (k == 0) return 1'b0;
        if (k <= DB) return b[k-1];
        return stop;
    endfunction

    task automatic model_reset();
        e_data  = '0;
        e_ready = 1'b0;
        e_ferr  = 1'b0;
        e_ovr   = 1'b0;
        comp_at = -1;
    endtask

    // One clock: drive at negedge, advance model at posedge, compare at next negedge.
    task automatic step(input logic lvl, input logic rd, input string tag);
        rxd = lvl;
        rdn = rd;
        @(posedge clk);
        edge_cnt++;
        if (edge_cnt == comp_at) begin
            e_ovr   = e_ready & rd;
            e_ready = 1'b1;
            e_data  = pend_data;
            e_ferr  = ~pend_stop;
            comp_at = -1;
        end else if (!rd) begin
            e_ready = 1'b0;
            e_ferr  = 1'b0;
            e_ovr   = 1'b0;
        end
        @(negedge clk);
        check(tag, dut_outs(), exp_outs());
    endtask

    task automatic idle(input int n, input int rd_at);
        for (int i = 0; i < n; i++) step(1'b1, (i == rd_at) ? 1'b0 : 1'b1, "idle");
    endtask

    task automatic send_frame(input logic [DB-1:0] b, input logic stop, input int rd_at,
                              input string tag);
        comp_at   = edge_cnt + COMP_EDGE;
        pend_data = b;
        pend_stop = stop;
        for (int i = 0; i < FRAME_LEN; i++)
            step(frame_bit(b, stop, i), (i == rd_at) ? 1'b0 : 1'b1, tag);
    endtask

    initial begin
        logic [DB-1:0] rb;
        logic          rs;
        int            rd_at;

        clrn = 1'b0;
        rxd  = 1'b1;
        rdn  = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_outs", dut_outs(), 32'h0);
        clrn = 1'b1;
        idle(6, -1);

        send_frame(8'hA5, 1'b1, -1, "a5_frame");
        check("a5_data", {24'b0, d_out}, 32'hA5);
        check("a5_flags", {29'b0, r_ready, frame_err, overrun}, 32'h4);
        step(1'b1, 1'b0, "a5_read");
        check("a5_ready_clr", {31'b0, r_ready}, 32'h0);
        check("a5_hold", {24'b0, d_out}, 32'hA5);
        idle(4, -1);

        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, "glitch");
        idle(20, -1);
        check("glitch_noready", {31'b0, r_ready}, 32'h0);
        send_frame(8'h3C, 1'b1, -1, "3c_frame");
        check("3c_data", {24'b0, d_out}, 32'h3C);
        idle(3, 0);

        send_frame(8'h81, 1'b0, -1, "81_frame");
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, "break");
        check("81_data", {24'b0, d_out}, 32'h81);
        check("81_flags", {29'b0, r_ready, frame_err, overrun}, 32'h6);
        idle(20, 5);
        check("81_read_clr", {29'b0, r_ready, frame_err, overrun}, 32'h0);

        send_frame(8'h11, 1'b1, -1, "ovr_11");
        idle(4, -1);
        send_frame(8'h22, 1'b1, -1, "ovr_22");
        check("ovr_data", {24'b0, d_out}, 32'h22);
        check("ovr_flags", {29'b0, r_ready, frame_err, overrun}, 32'h5);
        step(1'b1, 1'b0, "ovr_read");
        check("ovr_read_clr", {29'b0, r_ready, frame_err, overrun}, 32'h0);
        idle(4, -1);

        send_frame(8'h11, 1'b1, -1, "same_11");
        idle(3, -1);
        send_frame(8'h5A, 1'b1, COMP_EDGE - 1, "same_5a");
        check("same_data", {24'b0, d_out}, 32'h5A);
        check("same_flags", {29'b0, r_ready, frame_err, overrun}, 32'h4);
        idle(4, 1);

        // Reset mid data bit 3; upper nibble all ones so the tail holds no falling edge.
        rb = {4'hF, 4'($urandom_range(0, 15))};
        comp_at   = edge_cnt + COMP_EDGE;
        pend_data = rb;
        pend_stop = 1'b1;
        for (int i = 0; i < 4 * OS + 5; i++) step(frame_bit(rb, 1'b1, i), 1'b1, "rst_pre");
        clrn = 1'b0;
        #1;
        model_reset();
        check("rst_async", dut_outs(), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold", dut_outs(), 32'h0);
        end
        clrn = 1'b1;
        for (int i = 4 * OS + 8; i < FRAME_LEN; i++)
            step(frame_bit(rb, 1'b1, i), 1'b1, "rst_tail");
        idle(10, -1);
        check("rst_noready", {31'b0, r_ready}, 32'h0);
        send_frame(8'hC3, 1'b1, -1, "c3_frame");
        check("c3_data", {24'b0, d_out}, 32'hC3);
        idle(3, 0);

        for (int n = 0; n < 25; n++) begin
            rb = DB'($urandom_range(0, 255));
            rs = ($urandom_range(0, 5) != 0);
            case ($urandom_range(0, 3))
                0: rd_at = COMP_EDGE - 1;
                1: rd_at = int'($urandom_range(0, FRAME_LEN - 1));
                default: rd_at = -1;
            endcase
            send_frame(rb, rs, rd_at, "rand_frame");
            idle(int'($urandom_range(1, 30)), int'($urandom_range(0, 40)));
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < int'($urandom_range(1, 7)); i++) step(1'b0, 1'b1, "rand_glitch");
                idle(12, -1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
